// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sharing logic: opcode constants understood by
// the core's combinational ALU, the number of requesters, and the default-width
// request payload type.
// -----------------------------------------------------------------------------
package alu_pkg;

   // Requesters sharing the ALU: 0 = main execute path, 1 = auxiliary unit.
   localparam int unsigned NUM_REQ = 2;

   localparam int unsigned ALU_DATA_WIDTH = 32;
   localparam int unsigned ALU_OP_WIDTH   = 4;

   // ALU operation codes. 4'b1110 and 4'b1111 are unassigned; the ALU returns 0.
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 4'b0000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 4'b0001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 4'b0010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 4'b0011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 4'b0100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 4'b0101;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 4'b0110;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 4'b0111;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 4'b1000;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 4'b1001;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 4'b1010;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 4'b1011;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_GE   = 4'b1100;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI  = 4'b1101;

   // Request payload at the core's native widths.
   typedef struct packed {
      logic [ALU_DATA_WIDTH-1:0] srca;
      logic [ALU_DATA_WIDTH-1:0] srcb;
      logic [ALU_OP_WIDTH-1:0]   op;
   } alu_req_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter.
//   elig  in  [1:0]  requester i may be granted this cycle
//   last  in  1      index of the most recently granted requester
//   grant out [1:0]  one-hot grant (all zero when nobody is eligible)
// When both are eligible the requester that did not win last time is chosen.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] elig,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      unique case (elig)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Time-shares one combinational ALU between two requesters. At most one request
// is accepted per cycle (round-robin on contention); the granted operands and
// opcode drive the ALU and its result is captured into that requester's
// one-entry response buffer.
//   clk         in   clock
//   reset       in   asynchronous active-high reset
//   req_valid   in   [1:0]   request i presents an operation
//   req_ready   out  [1:0]   request i accepted this cycle (combinational)
//   req_srca    in   [2][DATA_WIDTH]    operand A per requester
//   req_srcb    in   [2][DATA_WIDTH]    operand B per requester
//   req_op      in   [2][OPCODE_LENGTH] operation per requester
//   rsp_valid   out  [1:0]   response buffer i holds a result
//   rsp_ready   in   [1:0]   requester i consumes its response
//   rsp_result  out  [2][DATA_WIDTH]    buffered result per requester
//   alu_srca    out  ALU operand A
//   alu_srcb    out  ALU operand B
//   alu_op      out  ALU operation
//   alu_result  in   ALU result for the operands currently driven
// -----------------------------------------------------------------------------
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [DATA_WIDTH-1:0]    req_srca [NUM_REQ],
   input  logic [DATA_WIDTH-1:0]    req_srcb [NUM_REQ],
   input  logic [OPCODE_LENGTH-1:0] req_op   [NUM_REQ],
   output logic [NUM_REQ-1:0]       rsp_valid,
   input  logic [NUM_REQ-1:0]       rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_result [NUM_REQ],
   output logic [DATA_WIDTH-1:0]    alu_srca,
   output logic [DATA_WIDTH-1:0]    alu_srcb,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0]    alu_result
);

   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_result_q [NUM_REQ];
   logic [DATA_WIDTH-1:0] rsp_result_d [NUM_REQ];
   logic                  last_q, last_d;

   logic [NUM_REQ-1:0] free;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] accept;

   // A buffer can take a new result if it is empty or being drained this cycle.
   assign free = ~rsp_valid_q | rsp_ready;
   assign elig = req_valid & free;

   rr_arb2 u_rr_arb2 (
      .elig  (elig),
      .last  (last_q),
      .grant (grant)
   );

   // Nothing is accepted and the ALU sits idle while reset is held.
   assign accept    = grant & {NUM_REQ{~reset}};
   assign req_ready = accept;

   always_comb begin
      alu_srca = '0;
      alu_srcb = '0;
      alu_op   = OPCODE_LENGTH'(ALU_AND);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            alu_srca = req_srca[i];
            alu_srcb = req_srcb[i];
            alu_op   = req_op[i];
         end
      end
   end

   // Accept wins over drain, so a same-cycle drain and accept reloads the buffer.
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      last_d       = last_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            rsp_valid_d[i]  = 1'b1;
            rsp_result_d[i] = alu_result;
         end else if (rsp_ready[i]) begin
            rsp_valid_d[i]  = 1'b0;
         end
      end
      if (|accept) begin
         last_d = accept[1];
      end
   end

   // last resets to 1 so the first contended grant goes to requester 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= '0;
         last_q      <= 1'b1;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_result_q[i] <= '0;
         end
      end else begin
         rsp_valid_q <= rsp_valid_d;
         last_q      <= last_d;
         for (int i = 0; i < NUM_REQ; i++) begin
            rsp_result_q[i] <= rsp_result_d[i];
         end
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;

endmodule
